// File: rtl/hmac_pkg.sv
// Shared constants and FSM encoding for the HMAC-SHA384 front end.
// Imported by the padder.
package hmac_pkg;

  localparam int BLOCK_WORDS = 32;
  localparam int KEY_BLOCK_BITS = 1024;
  localparam int LEN_FIELD_BITS = 128;
  localparam logic [7:0] PAD_MARKER = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PAD,
    SEND,
    WAIT
  } pad_state_e;

endpackage

// File: rtl/hmac_msg_padder.sv
// Packs a byte stream into 1024-bit SHA-384 blocks, pads it,
// drives hmac_core init/next and latches the final tag.
module hmac_msg_padder
  import hmac_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          msg_valid,
  output logic          msg_ready,
  input  logic [31:0]   msg_data,
  input  logic          msg_last,
  input  logic [2:0]    msg_bytes,
  output logic          core_init,
  output logic          core_next,
  output logic [1023:0] core_block,
  input  logic          core_ready,
  input  logic          core_tag_valid,
  input  logic [383:0]  core_tag,
  output logic [383:0]  tag,
  output logic          tag_valid,
  output logic          busy
);

  localparam int LB = LEN_W + 4;

  pad_state_e state, state_n;

  logic [31:0]      blk [BLOCK_WORDS];
  logic [4:0]       widx;
  logic [LEN_W-1:0] byte_cnt;
  logic             first_blk_done;
  logic             mark_pend;
  logic             len_here;
  logic             pad_pending;
  logic             final_blk;

  logic             wr_en;
  logic [4:0]       wr_idx;
  logic [31:0]      wr_data;
  logic             acc;
  logic [2:0]       nbytes;
  logic [LB-1:0]    len_bits;
  logic [LEN_FIELD_BITS-1:0] len_field;
  logic             wait_done;

  function automatic logic [31:0] tail_word(
    input logic [31:0] d,
    input logic [2:0]  n
  );
    logic [31:0] w;
    unique case (n)
      3'd0:    w = {PAD_MARKER, 24'h0};
      3'd1:    w = {d[31:24], PAD_MARKER, 16'h0};
      3'd2:    w = {d[31:16], PAD_MARKER, 8'h0};
      3'd3:    w = {d[31:8], PAD_MARKER};
      default: w = d;
    endcase
    return w;
  endfunction

  // Marker wins; length only lands here once the marker fits below word 28.
  function automatic logic [31:0] pad_word(
    input logic [4:0]                idx,
    input logic                      mark,
    input logic                      len_ok,
    input logic [LEN_FIELD_BITS-1:0] len
  );
    logic [31:0] w;
    w = '0;
    if (mark) begin
      w = {PAD_MARKER, 24'h0};
    end else if (len_ok && idx >= 5'd28) begin
      unique case (idx[1:0])
        2'd0: w = len[127:96];
        2'd1: w = len[95:64];
        2'd2: w = len[63:32];
        2'd3: w = len[31:0];
      endcase
    end
    return w;
  endfunction

  assign msg_ready = (state == IDLE) || (state == FILL);
  assign busy = (state != IDLE);
  assign acc = msg_valid && msg_ready;
  assign nbytes = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;
  assign len_bits = {1'b0, byte_cnt, 3'b000}
                  + LB'(KEY_BLOCK_BITS);
  assign len_field = LEN_FIELD_BITS'(len_bits);
  assign wait_done = core_ready && core_tag_valid;

  for (genvar i = 0; i < BLOCK_WORDS; i++) begin : g_blk
    assign core_block[1023-32*i -: 32] = blk[i];
  end

  always_comb begin
    state_n = state;
    wr_en = 1'b0;
    wr_idx = widx;
    wr_data = msg_data;
    core_init = 1'b0;
    core_next = 1'b0;
    unique case (state)
      IDLE: begin
        if (msg_valid) begin
          wr_en = 1'b1;
          wr_idx = 5'd0;
          if (msg_last) begin
            wr_data = tail_word(msg_data, nbytes);
            state_n = PAD;
          end else begin
            state_n = FILL;
          end
        end
      end
      FILL: begin
        if (msg_valid) begin
          wr_en = 1'b1;
          if (msg_last) begin
            wr_data = tail_word(msg_data, nbytes);
          end
          if (widx == 5'd31) begin
            state_n = SEND;
          end else if (msg_last) begin
            state_n = PAD;
          end
        end
      end
      PAD: begin
        wr_en = 1'b1;
        wr_data = pad_word(widx, mark_pend,
                           len_here, len_field);
        if (widx == 5'd31) begin
          state_n = SEND;
        end
      end
      SEND: begin
        if (core_ready) begin
          core_init = !first_blk_done;
          core_next = first_blk_done;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (wait_done) begin
          if (final_blk) begin
            state_n = IDLE;
          end else if (pad_pending) begin
            state_n = PAD;
          end else begin
            state_n = FILL;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      for (int i = 0; i < BLOCK_WORDS; i++) begin
        blk[i] <= '0;
      end
      widx <= '0;
      byte_cnt <= '0;
      first_blk_done <= 1'b0;
      mark_pend <= 1'b0;
      len_here <= 1'b0;
      pad_pending <= 1'b0;
      final_blk <= 1'b0;
      tag <= '0;
      tag_valid <= 1'b0;
    end else begin
      state <= state_n;
      if (wr_en) begin
        blk[wr_idx] <= wr_data;
      end
      unique case (state)
        IDLE: begin
          if (acc) begin
            byte_cnt <= msg_last ? LEN_W'(nbytes)
                                 : LEN_W'(4);
            first_blk_done <= 1'b0;
            tag_valid <= 1'b0;
            widx <= 5'd1;
            mark_pend <= msg_last && (nbytes == 3'd4);
            len_here <= msg_last && (nbytes != 3'd4);
            pad_pending <= 1'b0;
            final_blk <= 1'b0;
          end
        end
        FILL: begin
          if (acc) begin
            byte_cnt <= byte_cnt
                      + (msg_last ? LEN_W'(nbytes)
                                  : LEN_W'(4));
            widx <= widx + 5'd1;
            if (msg_last) begin
              mark_pend <= (nbytes == 3'd4);
              len_here <= (nbytes != 3'd4)
                       && (widx <= 5'd27);
            end
            if (widx == 5'd31) begin
              pad_pending <= msg_last;
            end
          end
        end
        PAD: begin
          widx <= widx + 5'd1;
          if (mark_pend) begin
            mark_pend <= 1'b0;
            len_here <= (widx <= 5'd27);
          end
          if (widx == 5'd31) begin
            final_blk <= len_here;
            pad_pending <= !len_here;
          end
        end
        SEND: begin
          if (core_ready) begin
            first_blk_done <= 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            if (final_blk) begin
              tag <= core_tag;
              tag_valid <= 1'b1;
            end else if (pad_pending) begin
              len_here <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hmac_msg_padder.sv
// Directed bench for hmac_msg_padder with a small hmac_core
// stand-in that records every block it is handed.
module tb_hmac_msg_padder;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          msg_valid = 1'b0;
  logic          msg_ready;
  logic [31:0]   msg_data = '0;
  logic          msg_last = 1'b0;
  logic [2:0]    msg_bytes = '0;
  logic          core_init;
  logic          core_next;
  logic [1023:0] core_block;
  logic          core_ready;
  logic          core_tag_valid;
  logic [383:0]  core_tag;
  logic [383:0]  tag;
  logic          tag_valid;
  logic          busy;

  int total = 0;
  int bad = 0;

  hmac_msg_padder #(.LEN_W(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .msg_valid(msg_valid),
    .msg_ready(msg_ready),
    .msg_data(msg_data),
    .msg_last(msg_last),
    .msg_bytes(msg_bytes),
    .core_init(core_init),
    .core_next(core_next),
    .core_block(core_block),
    .core_ready(core_ready),
    .core_tag_valid(core_tag_valid),
    .core_tag(core_tag),
    .tag(tag),
    .tag_valid(tag_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // core stand-in: busy 10 cycles per block, tag_valid stays high
  logic [1023:0] blocks [$];
  logic [1023:0] held;
  int            busy_cnt;
  int            op_id = 0;
  int            n_init = 0;
  int            n_next = 0;
  int            overlap = 0;
  int            unstable = 0;
  logic          stall = 1'b0;

  assign core_ready = (busy_cnt == 0) && !stall;

  function automatic logic [383:0] tag_pat(input int id);
    return {12{32'hC0DE0000 | 32'(id)}};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_cnt <= 0;
      core_tag_valid <= 1'b0;
      core_tag <= '0;
    end else begin
      if (core_init && core_next) overlap <= overlap + 1;
      if (core_init || core_next) begin
        blocks.push_back(core_block);
        held <= core_block;
        busy_cnt <= 10;
        op_id <= op_id + 1;
        if (core_init) n_init <= n_init + 1;
        if (core_next) n_next <= n_next + 1;
      end else if (busy_cnt > 0) begin
        if (core_block != held) unstable <= unstable + 1;
        busy_cnt <= busy_cnt - 1;
        if (busy_cnt == 1) begin
          core_tag_valid <= 1'b1;
          core_tag <= tag_pat(op_id);
        end
      end
    end
  end

  task automatic check(input string name,
                       input logic [383:0] got,
                       input logic [383:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [1023:0] b,
                                     input int i);
    return b[1023-32*i -: 32];
  endfunction

  function automatic logic [7:0] mbyte(input int k,
                                       input logic [7:0] base);
    return 8'(int'(base) + k);
  endfunction

  // textbook SHA-384 padding over a byte array
  function automatic logic [1023:0] exp_blk(input int n,
                                            input logic [7:0] base,
                                            input int bi);
    logic [7:0]    b [256];
    logic [127:0]  len;
    logic [1023:0] r;
    int            tot;
    for (int i = 0; i < 256; i++) b[i] = 8'h00;
    for (int k = 0; k < n; k++) b[k] = mbyte(k, base);
    b[n] = 8'h80;
    tot = ((n + 1 + 16 + 127) / 128) * 128;
    len = 128'(1024 + 8 * n);
    for (int j = 0; j < 16; j++) b[tot-16+j] = len[127-8*j -: 8];
    r = '0;
    for (int j = 0; j < 128; j++) r[1023-8*j -: 8] = b[bi*128+j];
    return r;
  endfunction

  task automatic send_msg(input int n, input logic [7:0] base,
                          input bit gaps);
    int nw;
    int t;
    logic [31:0] w;
    nw = (n == 0) ? 1 : (n + 3) / 4;
    for (int i = 0; i < nw; i++) begin
      @(negedge clk);
      if (gaps) begin
        msg_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      for (int j = 0; j < 4; j++) begin
        w[31-8*j -: 8] = (4*i + j < n) ? mbyte(4*i + j, base) : 8'hEE;
      end
      msg_valid = 1'b1;
      msg_data = w;
      msg_last = (i == nw - 1);
      msg_bytes = (i == nw - 1) ? 3'(n - 4*i) : 3'd4;
      t = 0;
      while (!msg_ready && t < 1000) begin
        @(negedge clk);
        t++;
      end
      if (t >= 1000) check("send_timeout", 1, 0);
      @(posedge clk);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last = 1'b0;
  endtask

  task automatic wait_tag(input string name);
    int t;
    t = 0;
    while (!tag_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check(name, tag_valid, 1);
  endtask

  int            nb;
  int            ni;
  int            nn;
  logic [1023:0] abc_blk;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", msg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_tagv", tag_valid, 0);
    check("rst_tag", tag, 0);
    check("rst_block", 384'(core_block[1023:640]), 0);
    check("rst_cmd", {core_init, core_next}, 0);
    reset_n = 1'b1;

    // empty message
    nb = blocks.size();
    send_msg(0, 8'h00, 0);
    wait_tag("empty_tagv");
    check("empty_nblk", blocks.size() - nb, 1);
    check("empty_w0", wd(blocks[nb], 0), 32'h80000000);
    check("empty_w30", wd(blocks[nb], 30), 0);
    check("empty_w31", wd(blocks[nb], 31), 32'h00000400);
    check("empty_blk", blocks[nb], exp_blk(0, 8'h00, 0));
    check("empty_init", n_init, 1);
    check("empty_tag", tag, tag_pat(op_id));

    // "abc"
    nb = blocks.size();
    ni = n_init;
    send_msg(3, 8'h61, 0);
    check("abc_tagv_clr", tag_valid, 0);
    check("abc_busy", busy, 1);
    wait_tag("abc_tagv");
    abc_blk = blocks[nb];
    check("abc_w0", wd(abc_blk, 0), 32'h61626380);
    check("abc_w31", wd(abc_blk, 31), 32'h00000418);
    check("abc_blk", abc_blk, exp_blk(3, 8'h61, 0));
    check("abc_init", n_init - ni, 1);
    check("abc_ready", msg_ready, 1);

    // 112 bytes: marker at word 28, length spills to block 2
    nb = blocks.size();
    ni = n_init;
    nn = n_next;
    send_msg(112, 8'h00, 0);
    wait_tag("b112_tagv");
    check("b112_nblk", blocks.size() - nb, 2);
    check("b112_w28", wd(blocks[nb], 28), 32'h80000000);
    check("b112_w31a", wd(blocks[nb], 31), 0);
    check("b112_blk0", blocks[nb], exp_blk(112, 8'h00, 0));
    check("b112_w0b", wd(blocks[nb+1], 0), 0);
    check("b112_w31b", wd(blocks[nb+1], 31), 32'h00000780);
    check("b112_blk1", blocks[nb+1], exp_blk(112, 8'h00, 1));
    check("b112_cmds", {32'(n_init - ni), 32'(n_next - nn)}, {32'd1, 32'd1});
    check("b112_tag", tag, tag_pat(op_id));

    // 128 bytes with input gaps and core_ready held low
    nb = blocks.size();
    ni = n_init;
    stall = 1'b1;
    send_msg(128, 8'h10, 1);
    repeat (50) @(negedge clk);
    check("b128_stalled", blocks.size() - nb, 0);
    check("b128_hold_busy", busy, 1);
    stall = 1'b0;
    wait_tag("b128_tagv");
    check("b128_nblk", blocks.size() - nb, 2);
    check("b128_blk0", blocks[nb], exp_blk(128, 8'h10, 0));
    check("b128_w0b", wd(blocks[nb+1], 0), 32'h80000000);
    check("b128_w31b", wd(blocks[nb+1], 31), 32'h00000800);
    check("b128_blk1", blocks[nb+1], exp_blk(128, 8'h10, 1));
    check("b128_init", n_init - ni, 1);
    check("overlap", overlap, 0);
    check("wait_stable", unstable, 0);

    // reset while waiting on the core
    nb = blocks.size();
    send_msg(3, 8'h61, 0);
    for (int t = 0; t < 500 && blocks.size() == nb; t++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", msg_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tagv", tag_valid, 0);
    check("mid_rst_tag", tag, 0);
    check("mid_rst_block", 384'(core_block[1023:640]), 0);
    @(negedge clk);
    reset_n = 1'b1;
    nb = blocks.size();
    ni = n_init;
    send_msg(3, 8'h61, 0);
    wait_tag("post_rst_tagv");
    check("post_rst_blk", blocks[nb], abc_blk);
    check("post_rst_init", n_init - ni, 1);
    check("post_rst_tag", tag, tag_pat(op_id));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=%0d exp=%0d", total, 0);
    $fatal(1);
  end

endmodule

// File: doc/hmac_msg_padder.md
# hmac_msg_padder

Streaming front end for `hmac_core`.
- Accepts an arbitrary-length message as 32-bit big-endian words and packs it into 1024-bit blocks.
- Appends SHA-384 padding, with the length field covering the 1024-bit ipad key block.
- Sequences `init_cmd`/`next_cmd` into the core and latches the final 384-bit tag.
- Sits directly upstream of `hmac_core`; the key is wired to the core separately and must be stable for the whole message.

## Interface
- LEN_W, 32: byte counter width; message length is N < 2^LEN_W bytes.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- msg_valid  in  1  input word valid
- msg_ready  out  1  padder accepts word this cycle
- msg_data  in  32  message word; first byte in [31:24]
- msg_last  in  1  final word of message
- msg_bytes  in  3  valid bytes in final word, 0..4; 0 is legal only for an empty message (single word with msg_last)
- core_init  out  1  one-cycle pulse to `hmac_core.init_cmd`
- core_next  out  1  one-cycle pulse to `hmac_core.next_cmd`
- core_block  out  1024  to `hmac_core.block_msg`; word index 0 is bits [1023:992]
- core_ready  in  1  `hmac_core.ready`
- core_tag_valid  in  1  `hmac_core.tag_valid`
- core_tag  in  384  `hmac_core.tag`
- tag  out  384  registered final HMAC tag
- tag_valid  out  1  level; high from capture until the first word of the next message is accepted
- busy  out  1  high in every state except IDLE

## Operation
- **FSM states:** IDLE, FILL, PAD, SEND, WAIT.
- **IDLE:** `msg_ready` is 1.
  - An accepted word clears the byte counter, clears `first_blk_done` and `tag_valid`, stores the word at index 0, and moves to FILL.
  - If that word also has `msg_last`, it moves straight to PAD.
- **FILL:** `msg_ready` is 1. Each accepted word is written at index `widx`, then `widx` increments (5 bits) and the byte counter adds 4 (or `msg_bytes` on the last word).
  - If `widx` wraps 31→0 without `msg_last`, go to SEND with `pad_pending` = 0, and return to FILL after WAIT.
- **0x80 marker placement:** on the last word with `msg_bytes` < 4, the byte after the last valid byte is 0x80 and the remaining bytes are 0. With `msg_bytes` = 4, the marker goes in the following word as 0x80000000, which may fall in the next block at index 0.
- **Marker position p:** the word index holding the 0x80 byte; p = 32 means it falls in the next block.
- **PAD:** `msg_ready` is 0. One word is written per cycle until index 31 inclusive.
  - Words before index 28 and words between the marker and index 28 are zero.
  - Words 28..31 hold the 128-bit value L = 1024 + 8·N, zero-extended from LEN_W+4 bits.
  - If p is 28..31, the rest of the block is zero-filled with no length, the block is sent, and a second block follows with words 0..27 zero plus the length.
  - If p = 32, the full data block is sent first; the next block has word 0 = 0x80000000, zeros, then the length.
- **SEND:** wait for `core_ready` = 1, then pulse `core_init` if `first_blk_done` = 0, otherwise `core_next`. Set `first_blk_done` and move to WAIT.
- **WAIT:** `core_block` is held stable. Exit when `core_ready` && `core_tag_valid`.
  - If the block just sent was the final padded block, latch `core_tag` → `tag`, set `tag_valid`, and go to IDLE.
  - Otherwise return to FILL or PAD.
- **Length arithmetic:** the byte counter wraps modulo 2^LEN_W; messages that long are unsupported and no error is raised.
- **Reset values:** all outputs 0 except `msg_ready` = 1 (IDLE); block buffer 0; `widx` 0.
- **Reset mid-operation:** return to IDLE and discard the partial message. The core shares `reset_n`.

## Timing
- Throughput in FILL is one word per cycle. Backpressure exists only during PAD, SEND and WAIT.
- PAD latency is (32 − current widx) cycles.
- SEND→pulse: same cycle if `core_ready` = 1.
- The command pulse is exactly one cycle. `core_init` and `core_next` are never high together.
- Exit from WAIT requires the cycle after the pulse, when the core has already dropped `ready`. `core_tag_valid` left high from an earlier operation is never mistaken for completion.
- `tag` and `tag_valid` update on the cycle after the WAIT exit condition is seen.

## Structure
- Shared `hmac_pkg` holds: BLOCK_WORDS = 32, KEY_BLOCK_BITS = 1024, LEN_FIELD_BITS = 128, PAD_MARKER = 8'h80, and the FSM state enum.
- Single module; no sub-module. The marker/length word mux is an internal function.

## Test plan
- **Empty message:** msg_bytes = 0, msg_last → one block; word0 = 0x80000000, words 1..30 = 0, word31 = 0x00000400; one `core_init`; `tag_valid` rises.
- **"abc":** word 0x61626300, bytes = 3 → word0 = 0x61626380, word31 = 0x00000418; single `core_init`.
- **112 bytes (p = 28):** block 1 has words 28..31 = 0. Block 2 has words 0..30 = 0, word31 = 0x00000780, sent via `core_next`. Tag is latched only after block 2.
- **128 bytes (p = 32):** block 1 is all data. Block 2 has word0 = 0x80000000, word31 = 0x00000800.
- **Backpressure and command exclusivity:** random `msg_valid` gaps plus `core_ready` held low 50 cycles in SEND → no word lost, single pulse, `core_block` stable through WAIT.
- **Reset mid-WAIT:** assert `reset_n` low → all outputs at reset values. A following "abc" message produces the identical block.
